// File: rtl/key_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared constants for the direction-key front end (key_pulse_gen).
//   - Index of each direction inside the 4-bit key vectors.
//   - Arbitration priority list: rank 0 wins, rank KEY_NUM-1 loses.
// -----------------------------------------------------------------------------
package key_pkg;

    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_NUM   = 4;

    // Priority list packed as 2-bit key indices; field r holds the key of rank r.
    // Order: up > down > left > right.
    localparam int KEY_IDX_W = 2;
    localparam logic [KEY_NUM*KEY_IDX_W-1:0] KEY_PRIO = {
        2'(KEY_RIGHT),  // rank 3
        2'(KEY_LEFT),   // rank 2
        2'(KEY_DOWN),   // rank 1
        2'(KEY_UP)      // rank 0
    };

endpackage

// File: rtl/key_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// key_pulse_gen_if
// Bundles the button inputs and the direction pulse / level outputs.
//   key_in     raw buttons, bit0 left, bit1 right, bit2 up, bit3 down
//   key_left   one-cycle press pulse
//   key_right  one-cycle press pulse
//   key_up     one-cycle press pulse
//   key_down   one-cycle press pulse
//   key_level  debounced pressed level per key, 1 = pressed
// Modports:
//   master  drives key_in, observes the outputs (board / testbench side)
//   slave   consumes key_in, drives the outputs (key_pulse_gen)
// -----------------------------------------------------------------------------
interface key_pulse_gen_if;
    import key_pkg::*;

    logic [KEY_NUM-1:0] key_in;
    logic               key_left;
    logic               key_right;
    logic               key_up;
    logic               key_down;
    logic [KEY_NUM-1:0] key_level;

    modport master (
        output key_in,
        input  key_left,
        input  key_right,
        input  key_up,
        input  key_down,
        input  key_level
    );

    modport slave (
        input  key_in,
        output key_left,
        output key_right,
        output key_up,
        output key_down,
        output key_level
    );

endinterface

// File: rtl/key_pulse_gen_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One key: 2-flop synchronizer, debounce counter, debounced level and a
// one-cycle-delayed copy of the level for edge detection.
//   clk            system clock
//   rst            asynchronous active-high reset (key treated as released)
//   pressed_i      raw key, already normalized to 1 = pressed
//   level_o        debounced level, 1 = pressed
//   level_prev_o   level_o delayed by one cycle
// A level change is accepted only after the synchronized input has differed
// from the current level for DB_CNT consecutive cycles.
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DB_CNT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed_i,
    output logic level_o,
    output logic level_prev_o
);

    localparam int CW = $clog2(DB_CNT);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any return of s2 to the current level restarts the count, so a glitch
    // shorter than DB_CNT cycles can never reach the accept point.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CNT - 1)) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= pressed_i;
            s2_q         <= s1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o      = level_q;
    assign level_prev_o = level_prev_q;

endmodule

// File: rtl/key_pulse_gen.sv
// -----------------------------------------------------------------------------
// key_pulse_gen
// Turns the four raw direction buttons into clean single-cycle direction
// pulses plus debounced key levels.
//   clk   system clock
//   rst   asynchronous active-high reset
//   kif   key_pulse_gen_if.slave:
//           key_in (raw buttons), key_left/right/up/down (one-cycle press
//           pulses), key_level (debounced levels, 1 = pressed)
// Per key: normalize polarity, synchronize, debounce, detect the rising edge.
// Simultaneous presses are arbitrated up > down > left > right; losers are
// dropped. All outputs come straight from flops.
// Optional build macro KEY_REPEAT_EN: while a key stays pressed, extra press
// events are generated REPEAT_DLY cycles after the accepted press and then
// every REPEAT_PER cycles. Without it REPEAT_DLY / REPEAT_PER are unused and
// no hold counters exist.
// -----------------------------------------------------------------------------
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int DB_CNT      = 1000000,
    parameter int KEY_ACT_LOW = 1,
    parameter int REPEAT_DLY  = 25000000,
    parameter int REPEAT_PER  = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    key_pulse_gen_if.slave   kif
);

    if (DB_CNT < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
        $error("key_pulse_gen: DB_CNT must be >= 2, REPEAT_DLY/REPEAT_PER >= 1");
    end

    logic [KEY_NUM-1:0] pressed;
    logic [KEY_NUM-1:0] level;
    logic [KEY_NUM-1:0] level_prev;
    logic [KEY_NUM-1:0] edge_raw;
    logic [KEY_NUM-1:0] press_raw;
    logic [KEY_NUM-1:0] grant;
    logic [KEY_NUM-1:0] pulse_q;

    assign pressed = (KEY_ACT_LOW != 0) ? ~kif.key_in : kif.key_in;

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        key_debounce #(
            .DB_CNT (DB_CNT)
        ) u_db (
            .clk          (clk),
            .rst          (rst),
            .pressed_i    (pressed[k]),
            .level_o      (level[k]),
            .level_prev_o (level_prev[k])
        );
    end

    assign edge_raw = level & ~level_prev;

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0]      hold_q [KEY_NUM];
    logic [RW-1:0]      hold_d [KEY_NUM];
    logic [KEY_NUM-1:0] periodic_q;
    logic [KEY_NUM-1:0] periodic_d;
    logic [KEY_NUM-1:0] rep_fire;

    // hold counts cycles since the accepted press (phase 0) or since the last
    // repeat (phase 1); it is held at 0 whenever the key is released.
    always_comb begin
        for (int k = 0; k < KEY_NUM; k++) begin
            rep_fire[k]   = level[k] &&
                            (hold_q[k] == (periodic_q[k] ? RW'(REPEAT_PER) : RW'(REPEAT_DLY)));
            hold_d[k]     = hold_q[k] + 1'b1;
            periodic_d[k] = periodic_q[k];
            if (!level[k]) begin
                hold_d[k]     = '0;
                periodic_d[k] = 1'b0;
            end else if (rep_fire[k]) begin
                hold_d[k]     = RW'(1);
                periodic_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < KEY_NUM; k++) begin
                hold_q[k] <= '0;
            end
            periodic_q <= '0;
        end else begin
            for (int k = 0; k < KEY_NUM; k++) begin
                hold_q[k] <= hold_d[k];
            end
            periodic_q <= periodic_d;
        end
    end

    assign press_raw = edge_raw | rep_fire;
`else
    assign press_raw = edge_raw;
`endif

    // Walk from lowest to highest rank so the highest-ranked request wins.
    always_comb begin
        grant = '0;
        for (int r = KEY_NUM - 1; r >= 0; r--) begin
            if (press_raw[KEY_PRIO[r*KEY_IDX_W +: KEY_IDX_W]]) begin
                grant = '0;
                grant[KEY_PRIO[r*KEY_IDX_W +: KEY_IDX_W]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= grant;
        end
    end

    assign kif.key_left  = pulse_q[KEY_LEFT];
    assign kif.key_right = pulse_q[KEY_RIGHT];
    assign kif.key_up    = pulse_q[KEY_UP];
    assign kif.key_down  = pulse_q[KEY_DOWN];
    assign kif.key_level = level;

endmodule

// File: tb/tb_key_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_key_pulse_gen
// Directed bench for key_pulse_gen with DB_CNT=8, KEY_ACT_LOW=1,
// REPEAT_DLY=20, REPEAT_PER=6. Inputs change 1 time unit after a rising edge;
// outputs are sampled 1 time unit after each rising edge. "Cycle n" below is
// the state right after the n-th rising edge following an input change.
// Expected pulse/level timing for an input change before edge 1:
//   level flips after edge DB+2 = 10, pulse after edge DB+3 = 11,
//   level falls DB+2 = 10 edges after a release.
// -----------------------------------------------------------------------------
module tb_key_pulse_gen;
    import key_pkg::*;

    localparam int DB   = 8;
    localparam int RDLY = 20;
    localparam int RPER = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_pulse_gen_if kif ();

    key_pulse_gen #(
        .DB_CNT      (DB),
        .KEY_ACT_LOW (1),
        .REPEAT_DLY  (RDLY),
        .REPEAT_PER  (RPER)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {kif.key_down, kif.key_up, kif.key_right, kif.key_left};
    endfunction

    // Pulse expected at cycle n for a press whose first pulse is at 'base' and
    // whose raw release happens after edge 'hold'. Repeats need level still 1
    // on the edge before the pulse, i.e. pulse cycle <= hold + DB + 2.
    function automatic bit exp_pulse(int n, int base, int hold);
        if (n == base) return 1'b1;
`ifdef KEY_REPEAT_EN
        if (n >= base + RDLY && ((n - base - RDLY) % RPER) == 0 && n <= hold + DB + 2)
            return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press 'keys' (1 = pressed) for 'hold' cycles, then release, and check
    // every cycle through the release debounce.
    task automatic press_test(input string tag, input logic [3:0] keys,
                              input int hold, input logic [3:0] win);
        kif.key_in = ~keys;
        for (int n = 1; n <= hold + DB + 6; n++) begin
            if (n == hold + 1) kif.key_in = 4'b1111;
            tick();
            check({tag, "_pulse"}, 32'(pulses()),
                  exp_pulse(n, DB + 3, hold) ? 32'(win) : 32'h0);
            check({tag, "_level"}, 32'(kif.key_level),
                  (n >= DB + 2 && n < hold + DB + 2) ? 32'(keys) : 32'h0);
        end
    endtask

    initial begin
        kif.key_in = 4'b1111;

        // Reset state
        repeat (3) tick();
        check("rst_pulse", 32'(pulses()), 32'h0);
        check("rst_level", 32'(kif.key_level), 32'h0);
        rst = 1'b0;
        repeat (5) tick();
        check("idle_pulse", 32'(pulses()), 32'h0);
        check("idle_level", 32'(kif.key_level), 32'h0);

        // Clean press of up
        press_test("clean", 4'b0100, 30, 4'b0100);

        // Bouncing left: toggles every 3 cycles for 20 cycles, final edge
        // after edge 18, so level rises at 28 and the pulse lands at 29.
        for (int n = 1; n <= 56; n++) begin
            int t;
            t = n - 1;
            if (t < 20) kif.key_in[0] = ((t / 3) % 2 == 0) ? 1'b0 : 1'b1;
            else        kif.key_in[0] = 1'b0;
            if (t >= 40) kif.key_in = 4'b1111;
            tick();
            check("bounce_pulse", 32'(pulses()),
                  exp_pulse(n, 29, 40) ? 32'h1 : 32'h0);
            check("bounce_level", 32'(kif.key_level),
                  (n >= 28 && n < 40 + DB + 2) ? 32'h1 : 32'h0);
        end

        // 7-cycle glitch on down never reaches DB_CNT
        kif.key_in = 4'b0111;
        for (int n = 1; n <= 20; n++) begin
            if (n == 8) kif.key_in = 4'b1111;
            tick();
            check("glitch_pulse", 32'(pulses()), 32'h0);
            check("glitch_level", 32'(kif.key_level), 32'h0);
        end

        // Left, up and down pressed together: only up pulses
        press_test("simul", 4'b1101, 25, 4'b0100);

        // Reset 4 cycles into a right press, key kept pressed
        kif.key_in = 4'b1101;
        for (int n = 1; n <= 4; n++) begin
            tick();
            check("pre_rst_pulse", 32'(pulses()), 32'h0);
        end
        rst = 1'b1;
        #1;
        check("async_rst_level", 32'(kif.key_level), 32'h0);
        for (int n = 1; n <= 2; n++) begin
            tick();
            check("in_rst_pulse", 32'(pulses()), 32'h0);
            check("in_rst_level", 32'(kif.key_level), 32'h0);
        end
        rst = 1'b0;
        press_test("post_rst", 4'b0010, 20, 4'b0010);

        // Long hold of right: auto-repeat when enabled, single pulse otherwise
        press_test("hold", 4'b0010, 50, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
